symbol_overlay_sched: RTL and testbench

//  Schedules the shared separator-glyph ROMs (colon dots, date slashes) for the VGA overlay.
//  Per pixel: matches 6 screen rectangles, picks one by priority, builds a column-major ROM address.

---
 rtl/sym_layout_pkg.sv | 59 +++++
 rtl/sym_region_match.sv | 24 ++
 rtl/symbol_overlay_sched.sv | 155 +++++++++++++++
 tb/tb_symbol_overlay_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sym_layout_pkg.sv
// Screen layout of the separator glyphs (colon dots, date slashes) and the
// shared types used by the overlay scheduler.
package sym_layout_pkg;

  localparam int NREG    = 6;              // overlay rectangles, index 0 = highest priority
  localparam int PIX_DIV = 4;              // clk cycles per pix_tick
  localparam int COORD_W = 10;             // pix_x / pix_y width
  localparam int OFS_W   = 9;              // in-rectangle offset width
  localparam int IDX_W   = $clog2(NREG);

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_DOTS  = 2'd1,
    CLS_SLASH = 2'd2
  } sym_class_t;

  typedef enum logic {
    BLINK_SHOW = 1'b0,
    BLINK_HIDE = 1'b1
  } blink_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
    sym_class_t         cls;
  } region_t;

  // Internal state made visible for checkers.
  typedef struct packed {
    blink_state_t     blink;
    logic [IDX_W-1:0] s1_idx;
    sym_class_t       s1_cls;
  } sched_dbg_t;

  // Bounds are exclusive on both sides.
  localparam region_t REGION_TAB [NREG] = '{
    '{10'd180, 10'd210, 10'd68,  10'd124, CLS_DOTS},
    '{10'd180, 10'd210, 10'd324, 10'd380, CLS_DOTS},
    '{10'd308, 10'd333, 10'd68,  10'd124, CLS_DOTS},
    '{10'd308, 10'd333, 10'd324, 10'd380, CLS_DOTS},
    '{10'd184, 10'd205, 10'd188, 10'd260, CLS_SLASH},
    '{10'd310, 10'd331, 10'd188, 10'd260, CLS_SLASH}
  };

  localparam logic [6:0] H_DOTS  = 7'd56;
  localparam logic [6:0] H_SLASH = 7'd72;

  // Column height of the glyph ROM for a class (column-major addressing).
  function automatic logic [6:0] glyph_height(input sym_class_t c);
    case (c)
      CLS_DOTS:  glyph_height = H_DOTS;
      CLS_SLASH: glyph_height = H_SLASH;
      default:   glyph_height = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/sym_region_match.sv
// One strict-bounds rectangle comparator plus the pixel offset inside it.
module sym_region_match
  import sym_layout_pkg::*;
#(
  parameter logic [COORD_W-1:0] X0 = '0,
  parameter logic [COORD_W-1:0] X1 = '0,
  parameter logic [COORD_W-1:0] Y0 = '0,
  parameter logic [COORD_W-1:0] Y1 = '0
) (
  input  logic               video_on,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               hit,
  output logic [OFS_W-1:0]   dx,
  output logic [OFS_W-1:0]   dy
);

  // Border pixels are excluded; blanking never matches.
  assign hit = video_on && (pix_x > X0) && (pix_x < X1) && (pix_y > Y0) && (pix_y < Y1);
  // Offsets are only meaningful when hit is set; rectangles are narrower than 512.
  assign dx  = OFS_W'(pix_x - X0);
  assign dy  = OFS_W'(pix_y - Y0);

endmodule

// File: rtl/symbol_overlay_sched.sv
// Separator-glyph overlay scheduler: rectangle match -> ROM address -> colour,
// three pix_tick stages, with colon blinking driven by the RTC seconds pulse.
//
// ROM port protocol: rom_en is a one-clk strobe issued the clk after a pix_tick
// whose stage-2 pixel lies in a glyph; rom_sel/rom_addr are stable from that
// strobe until the next pix_tick; rom_rdata must be valid one clk after rom_en
// and held until the following pix_tick, where it is captured. No backpressure.
module symbol_overlay_sched
  import sym_layout_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RGB_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_tick,
  input  logic               video_on,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               blink_tick,
  input  logic               blink_en,
  output logic               rom_en,
  output logic [1:0]         rom_sel,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [RGB_W-1:0]   rom_rdata,
  output logic               sym_on,
  output logic [RGB_W-1:0]   rgb_out,
  output sched_dbg_t         dbg
);

  logic [NREG-1:0]  hit;
  logic [OFS_W-1:0] dx_v [NREG];
  logic [OFS_W-1:0] dy_v [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_match
    sym_region_match #(
      .X0(REGION_TAB[g].x0),
      .X1(REGION_TAB[g].x1),
      .Y0(REGION_TAB[g].y0),
      .Y1(REGION_TAB[g].y1)
    ) u_match (
      .video_on(video_on),
      .pix_x   (pix_x),
      .pix_y   (pix_y),
      .hit     (hit[g]),
      .dx      (dx_v[g]),
      .dy      (dy_v[g])
    );
  end

  sym_class_t       sel_cls;
  logic [IDX_W-1:0] sel_idx;
  logic [OFS_W-1:0] sel_dx, sel_dy;

  // Priority encoder: scan from lowest priority so the lowest hit index wins.
  always_comb begin
    sel_cls = CLS_NONE;
    sel_idx = '0;
    sel_dx  = '0;
    sel_dy  = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_cls = REGION_TAB[i].cls;
        sel_idx = IDX_W'(i);
        sel_dx  = dx_v[i];
        sel_dy  = dy_v[i];
      end
    end
  end

  sym_class_t       s1_cls;
  logic [IDX_W-1:0] s1_idx;
  logic [OFS_W-1:0] s1_dx, s1_dy;

  // Stage 1: latch the winning rectangle and offsets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_cls <= CLS_NONE;
      s1_idx <= '0;
      s1_dx  <= '0;
      s1_dy  <= '0;
    end else if (pix_tick) begin
      s1_cls <= sel_cls;
      s1_idx <= sel_idx;
      s1_dx  <= sel_dx;
      s1_dy  <= sel_dy;
    end
  end

  sym_class_t        s2_cls;
  logic [ADDR_W-1:0] addr_next;

  assign addr_next = ADDR_W'(s1_dy) + ADDR_W'(s1_dx) * ADDR_W'(glyph_height(s1_cls));

  // Stage 2: column-major address, ROM select and the single read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_cls   <= CLS_NONE;
      rom_addr <= '0;
      rom_en   <= 1'b0;
    end else begin
      rom_en <= pix_tick && (s1_cls != CLS_NONE);
      if (pix_tick) begin
        s2_cls   <= s1_cls;
        rom_addr <= addr_next;
      end
    end
  end

  assign rom_sel = s2_cls;

  blink_state_t blink_q, blink_d;
  logic         blink_hide;

  // Blink FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) blink_q <= BLINK_SHOW;
    else        blink_q <= blink_d;
  end

  // Blink FSM next state: disabling blinking wins over a coincident tick.
  always_comb begin
    blink_d = blink_q;
    if (!blink_en) begin
      blink_d = BLINK_SHOW;
    end else if (blink_tick) begin
      blink_d = (blink_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
    end
  end

  // Blink FSM outputs and debug view.
  always_comb begin
    blink_hide    = (blink_q == BLINK_HIDE);
    dbg           = '0;
    dbg.blink     = blink_q;
    dbg.s1_idx    = s1_idx;
    dbg.s1_cls    = s1_cls;
  end

  logic visible;

  assign visible = (s2_cls != CLS_NONE) && !((s2_cls == CLS_DOTS) && blink_hide);

  // Stage 3: blink state is sampled only here, so a glyph pixel never changes mid-pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_on  <= 1'b0;
      rgb_out <= '0;
    end else if (pix_tick) begin
      sym_on  <= visible;
      rgb_out <= visible ? rom_rdata : '0;
    end
  end

endmodule

// File: tb/tb_symbol_overlay_sched.sv
// Directed bench for symbol_overlay_sched with a registered ROM model.
module tb_symbol_overlay_sched;
  import sym_layout_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pix_tick = 1'b0;
  logic              video_on = 1'b0;
  logic [9:0]        pix_x = '0;
  logic [9:0]        pix_y = '0;
  logic              blink_tick = 1'b0;
  logic              blink_en = 1'b0;
  logic              rom_en;
  logic [1:0]        rom_sel;
  logic [15:0]       rom_addr;
  logic [11:0]       rom_rdata = '0;
  logic              sym_on;
  logic [11:0]       rgb_out;
  sched_dbg_t        dbg;

  int errors = 0;
  int checks = 0;
  int rom_en_cnt = 0;
  logic [12:0] exp_q[$];

  symbol_overlay_sched #(.ADDR_W(16), .RGB_W(12)) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .blink_tick(blink_tick), .blink_en(blink_en),
    .rom_en(rom_en), .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .sym_on(sym_on), .rgb_out(rgb_out), .dbg(dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ROM model: word = {select, low 10 address bits}, valid 1 clk after rom_en.
  always @(posedge clk) if (rom_en) rom_rdata <= {rom_sel, rom_addr[9:0]};

  // strobe counter
  always @(negedge clk) if (rom_en) rom_en_cnt++;

  // driver: one pixel period, pix_tick (and optionally blink_tick) in the first clk
  task automatic do_pixel(input logic [9:0] x, input logic [9:0] y, input logic vo, input logic bt);
    @(negedge clk);
    pix_x = x; pix_y = y; video_on = vo; pix_tick = 1'b1; blink_tick = bt;
    @(negedge clk);
    pix_tick = 1'b0; blink_tick = 1'b0;
    repeat (PIX_DIV - 2) @(negedge clk);
  endtask

  task automatic fill();
    do_pixel(10'd0, 10'd0, 1'b1, 1'b0);
  endtask

  task automatic blink_pulse();
    @(negedge clk); blink_tick = 1'b1;
    @(negedge clk); blink_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en: got %b want 0", rom_en); end
    checks++; if (rom_sel !== 2'd0) begin errors++; $display("FAIL rst_rom_sel: got %0d want 0", rom_sel); end
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL rst_sym_on: got %b want 0", sym_on); end
    checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL rst_rgb: got %h want 000", rgb_out); end
    checks++; if (dbg.blink !== BLINK_SHOW) begin errors++; $display("FAIL rst_blink: got %0d want SHOW", dbg.blink); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dots_addr();
    rom_en_cnt = 0;
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    fill();
    checks++; if (rom_sel !== 2'd1) begin errors++; $display("FAIL t1_rom_sel: got %0d want 1", rom_sel); end
    checks++; if (rom_addr !== 16'd57) begin errors++; $display("FAIL t1_rom_addr: got %0d want 57", rom_addr); end
    checks++; if (rom_en_cnt !== 1) begin errors++; $display("FAIL t1_rom_en_cnt: got %0d want 1", rom_en_cnt); end
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t1_early_sym_on: got %b want 0", sym_on); end
    fill();
    checks++; if (rgb_out !== 12'h439) begin errors++; $display("FAIL t1_rgb: got %h want 439", rgb_out); end
    checks++; if (sym_on !== 1'b1) begin errors++; $display("FAIL t1_sym_on: got %b want 1", sym_on); end
  endtask

  task automatic test_slash_bounds();
    do_pixel(10'd185, 10'd189, 1'b1, 1'b0);
    fill();
    checks++; if (rom_sel !== 2'd2) begin errors++; $display("FAIL t2_rom_sel: got %0d want 2", rom_sel); end
    checks++; if (rom_addr !== 16'd73) begin errors++; $display("FAIL t2_rom_addr: got %0d want 73", rom_addr); end
    fill();
    checks++; if (rgb_out !== 12'h849) begin errors++; $display("FAIL t2_rgb: got %h want 849", rgb_out); end
    rom_en_cnt = 0;
    do_pixel(10'd180, 10'd69, 1'b1, 1'b0);
    do_pixel(10'd210, 10'd100, 1'b1, 1'b0);
    do_pixel(10'd181, 10'd124, 1'b1, 1'b0);
    checks++; if (rom_sel !== 2'd0) begin errors++; $display("FAIL t2_edge_rom_sel: got %0d want 0", rom_sel); end
    fill();
    fill();
    checks++; if (rom_en_cnt !== 0) begin errors++; $display("FAIL t2_edge_rom_en_cnt: got %0d want 0", rom_en_cnt); end
    checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL t2_edge_rgb: got %h want 000", rgb_out); end
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t2_edge_sym_on: got %b want 0", sym_on); end
  endtask

  task automatic test_video_off();
    rom_en_cnt = 0;
    do_pixel(10'd190, 10'd100, 1'b0, 1'b0);
    fill();
    fill();
    checks++; if (rom_en_cnt !== 0) begin errors++; $display("FAIL t3_rom_en_cnt: got %0d want 0", rom_en_cnt); end
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t3_sym_on: got %b want 0", sym_on); end
  endtask

  task automatic test_blink();
    blink_en = 1'b1;
    blink_pulse();
    checks++; if (dbg.blink !== BLINK_HIDE) begin errors++; $display("FAIL t4_state_hide: got %0d want HIDE", dbg.blink); end
    rom_en_cnt = 0;
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    fill();
    fill();
    checks++; if (rom_en_cnt !== 1) begin errors++; $display("FAIL t4_hidden_rom_en_cnt: got %0d want 1", rom_en_cnt); end
    checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL t4_hidden_rgb: got %h want 000", rgb_out); end
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t4_hidden_sym_on: got %b want 0", sym_on); end
    do_pixel(10'd185, 10'd189, 1'b1, 1'b0);
    fill();
    fill();
    checks++; if (rgb_out !== 12'h849) begin errors++; $display("FAIL t4_slash_rgb: got %h want 849", rgb_out); end
    checks++; if (sym_on !== 1'b1) begin errors++; $display("FAIL t4_slash_sym_on: got %b want 1", sym_on); end
    blink_pulse();
    checks++; if (dbg.blink !== BLINK_SHOW) begin errors++; $display("FAIL t4_state_show: got %0d want SHOW", dbg.blink); end
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    fill();
    fill();
    checks++; if (rgb_out !== 12'h439) begin errors++; $display("FAIL t4_restored_rgb: got %h want 439", rgb_out); end
    // blink_tick in the same clk as pix_tick: both must take effect
    do_pixel(10'd181, 10'd69, 1'b1, 1'b1);
    checks++; if (dbg.blink !== BLINK_HIDE) begin errors++; $display("FAIL t4_coincident_state: got %0d want HIDE", dbg.blink); end
    fill();
    fill();
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t4_coincident_sym_on: got %b want 0", sym_on); end
    blink_pulse();
  endtask

  task automatic test_blink_override();
    blink_en = 1'b1;
    blink_pulse();
    checks++; if (dbg.blink !== BLINK_HIDE) begin errors++; $display("FAIL t5_pre_hide: got %0d want HIDE", dbg.blink); end
    @(negedge clk); blink_en = 1'b0; blink_tick = 1'b1;
    @(negedge clk); blink_tick = 1'b0;
    checks++; if (dbg.blink !== BLINK_SHOW) begin errors++; $display("FAIL t5_tick_off_show: got %0d want SHOW", dbg.blink); end
    blink_en = 1'b1;
    blink_pulse();
    @(negedge clk); blink_en = 1'b0;
    @(negedge clk);
    checks++; if (dbg.blink !== BLINK_SHOW) begin errors++; $display("FAIL t5_off_show: got %0d want SHOW", dbg.blink); end
    blink_pulse();
    checks++; if (dbg.blink !== BLINK_SHOW) begin errors++; $display("FAIL t5_off_tick_stays: got %0d want SHOW", dbg.blink); end
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    fill();
    fill();
    checks++; if (rgb_out !== 12'h439) begin errors++; $display("FAIL t5_dots_rgb: got %h want 439", rgb_out); end
  endtask

  task automatic test_reset_midline();
    blink_en = 1'b0;
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    do_pixel(10'd182, 10'd69, 1'b1, 1'b0);
    do_pixel(10'd183, 10'd69, 1'b1, 1'b0);
    checks++; if (sym_on !== 1'b1) begin errors++; $display("FAIL t6_pre_sym_on: got %b want 1", sym_on); end
    pix_x = 10'd184; pix_y = 10'd69;
    reset = 1'b0;
    #1;
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t6_async_sym_on: got %b want 0", sym_on); end
    checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL t6_async_rgb: got %h want 000", rgb_out); end
    checks++; if (rom_sel !== 2'd0) begin errors++; $display("FAIL t6_async_rom_sel: got %0d want 0", rom_sel); end
    checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL t6_async_rom_addr: got %0d want 0", rom_addr); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t6_tick1_sym_on: got %b want 0", sym_on); end
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    checks++; if (sym_on !== 1'b0) begin errors++; $display("FAIL t6_tick2_sym_on: got %b want 0", sym_on); end
    do_pixel(10'd181, 10'd69, 1'b1, 1'b0);
    checks++; if (sym_on !== 1'b1) begin errors++; $display("FAIL t6_tick3_sym_on: got %b want 1", sym_on); end
    checks++; if (rgb_out !== 12'h439) begin errors++; $display("FAIL t6_tick3_rgb: got %h want 439", rgb_out); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  xs [7];
    logic [9:0]  ys [7];
    logic [12:0] ev [7];
    logic [12:0] exp_v;
    xs = '{10'd181, 10'd182, 10'd185, 10'd0, 10'd309, 10'd200, 10'd320};
    ys = '{10'd69,  10'd70,  10'd189, 10'd0, 10'd69,  10'd350, 10'd200};
    ev = '{13'h1439, 13'h1472, 13'h1849, 13'h0000, 13'h1439, 13'h147A, 13'h1ADC};
    blink_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        exp_q.push_back(ev[i]);
        do_pixel(xs[i], ys[i], 1'b1, 1'b0);
      end else begin
        exp_q.push_back(13'h0000);
        fill();
      end
      if (i >= 2) begin
        exp_v = exp_q.pop_front();
        checks++;
        if ({sym_on, rgb_out} !== exp_v) begin
          errors++;
          $display("FAIL b2b_pix%0d: got sym_on=%b rgb=%h want sym_on=%b rgb=%h",
                   i - 2, sym_on, rgb_out, exp_v[12], exp_v[11:0]);
        end
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_dots_addr();
    test_slash_bounds();
    test_video_off();
    test_blink();
    test_blink_override();
    test_back_to_back();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
